// File: rtl/bcm_row_scheduler_if.sv
// Handshake bundle between the BCM row scheduler, the pixel generator
// and the HUB-75 shift driver. The scheduler side uses the master modport.
interface bcm_row_scheduler_if #(
  parameter int PLANE_W = 3
);
  logic               row_request;
  logic               row_ready;
  logic [4:0]         row_index;
  logic               shift_start;
  logic [PLANE_W-1:0] shift_plane;
  logic               shift_idle;
  logic [4:0]         abcde;
  logic               lat;
  logic               oe;
  logic               frame_done;

  modport master (
    output row_request, row_index, shift_start, shift_plane,
           abcde, lat, oe, frame_done,
    input  row_ready, shift_idle
  );

  modport slave (
    input  row_request, row_index, shift_start, shift_plane,
           abcde, lat, oe, frame_done,
    output row_ready, shift_idle
  );
endinterface

// File: rtl/bcm_row_scheduler.sv
// BCM row scheduler for a HUB-75 panel: requests row data, launches one
// shift per bit plane, times OE windows of BASE_TICKS<<plane and blanks
// around row-address changes. The shift of plane p+1 overlaps the display
// of plane p. Optional macro BCM_DIMMING_EN adds a dim[2:0] input that
// shortens the lit part of every window to W>>dim without changing timing.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | stopped, oe blanked once the last window has run out
// WAIT_ROW   | row_request high until the generator answers row_ready
// SHIFT      | one-cycle shift_start for (row_index, shift_plane)
// WAIT_SHIFT | wait for driver idle and the current window to end
// BLANK      | row change: new abcde, BLANK_TICKS cycles with oe high
// LATCH      | lat pulse, window timer reloads, advance plane/row
module bcm_row_scheduler #(
  parameter int PLANE_COUNT = 8,
  parameter int ROW_COUNT   = 32,
  parameter int BASE_TICKS  = 16,
  parameter int BLANK_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
`ifdef BCM_DIMMING_EN
  input  logic [2:0] dim,
`endif
  bcm_row_scheduler_if.master bus
);
  localparam int PW = $clog2(PLANE_COUNT);
  localparam int TW = $clog2(BASE_TICKS) + PLANE_COUNT;
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_ROW, SHIFT, WAIT_SHIFT, BLANK, LATCH} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] window;
  logic [4:0]    row_index;
  logic [4:0]    abcde;
  logic [PW-1:0] plane;
  logic [BW-1:0] blank_cnt;
  logic          ws_first;
  logic          oe_q;
  logic          oe_src;
  logic          last_plane;
  logic          last_row;

  assign last_plane = (plane == PW'(PLANE_COUNT - 1));
  assign last_row   = (row_index == 5'(ROW_COUNT - 1));
  assign window     = TW'(BASE_TICKS) << plane;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and the pulse/level outputs tied to the state
  always_comb begin
    state_nxt       = state;
    bus.row_request = 1'b0;
    bus.shift_start = 1'b0;
    bus.lat         = 1'b0;
    bus.frame_done  = 1'b0;
    unique case (state)
      IDLE: if (enable) state_nxt = WAIT_ROW;
      WAIT_ROW: begin
        bus.row_request = 1'b1;
        if (bus.row_ready) state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.shift_start = 1'b1;
        state_nxt       = WAIT_SHIFT;
      end
      // the driver may still report idle in the first cycle, so skip it
      WAIT_SHIFT: begin
        if (!ws_first && bus.shift_idle && timer == '0)
          state_nxt = (plane == '0) ? BLANK : LATCH;
      end
      BLANK: if (blank_cnt == '0) state_nxt = LATCH;
      LATCH: begin
        bus.lat        = 1'b1;
        bus.frame_done = last_plane && last_row;
        if (!last_plane)              state_nxt = SHIFT;
        else if (last_row && !enable) state_nxt = IDLE;
        else                          state_nxt = WAIT_ROW;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row/plane bookkeeping, displayed row address and blank counter
  always_ff @(posedge clock) begin
    if (reset) begin
      row_index <= '0;
      plane     <= '0;
      abcde     <= '0;
      blank_cnt <= '0;
      ws_first  <= 1'b0;
    end else begin
      ws_first <= (state == SHIFT);
      if (state == WAIT_SHIFT && state_nxt == BLANK) begin
        abcde     <= row_index;
        blank_cnt <= BW'(BLANK_TICKS - 1);
      end else if (state == BLANK && blank_cnt != '0) begin
        blank_cnt <= blank_cnt - BW'(1);
      end
      if (state == LATCH) begin
        if (last_plane) begin
          plane     <= '0;
          row_index <= last_row ? 5'd0 : row_index + 5'd1;
        end else begin
          plane <= plane + PW'(1);
        end
      end
    end
  end

  // Display window: reload after lat, count down to zero and hold
  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
      oe_q  <= 1'b1;
    end else begin
      if (state == LATCH)    timer <= window;
      else if (timer != '0) timer <= timer - TW'(1);
      oe_q <= oe_src;
    end
  end

`ifdef BCM_DIMMING_EN
  logic [TW-1:0] on_timer;

  // Lit portion of the window; the sequencing timer above is unaffected
  always_ff @(posedge clock) begin
    if (reset)                  on_timer <= '0;
    else if (state == LATCH)    on_timer <= window >> dim;
    else if (on_timer != '0)    on_timer <= on_timer - TW'(1);
  end

  assign oe_src = (on_timer == '0);
`else
  assign oe_src = (timer == '0);
`endif

  assign bus.oe          = oe_q;
  assign bus.abcde       = abcde;
  assign bus.row_index   = row_index;
  assign bus.shift_plane = plane;
endmodule

// File: tb/tb_bcm_row_scheduler.sv
// Scoreboard bench for bcm_row_scheduler: the stimulus side pushes the
// expected shift/latch sequence of each frame, a negedge monitor pops and
// compares whenever the DUT shows shift_start or lat, and times OE windows.
module tb_bcm_row_scheduler;
  localparam int PC  = 2;
  localparam int RC  = 2;
  localparam int BT  = 4;
  localparam int BLK = 2;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
`ifdef BCM_DIMMING_EN
  logic [2:0] dim = 3'd0;
`endif

  bcm_row_scheduler_if #(.PLANE_W(1)) bus ();

  bcm_row_scheduler #(
    .PLANE_COUNT(PC), .ROW_COUNT(RC), .BASE_TICKS(BT), .BLANK_TICKS(BLK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
`ifdef BCM_DIMMING_EN
    .dim   (dim),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {int row; int plane;} shift_t;
  typedef struct {int row; int plane; int fd; int win;} lat_t;

  shift_t exp_shift[$];
  lat_t   exp_lat[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic void check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference: every frame walks rows in order, planes LSB first; plane p
  // is lit for (BT<<p)>>dim cycles; frame_done only on the very last latch.
  task automatic push_frames(int nf, int dv);
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < RC; r++)
        for (int p = 0; p < PC; p++) begin
          shift_t s;
          lat_t   l;
          s.row = r; s.plane = p;
          l.row = r; l.plane = p;
          l.fd  = (r == RC - 1 && p == PC - 1) ? 1 : 0;
          l.win = (BT << p) >> dv;
          exp_shift.push_back(s);
          exp_lat.push_back(l);
        end
  endtask

  // Generator and shift driver models
  int max_busy = 3;
  int max_rdy  = 0;
  int busy     = 0;
  int rdelay   = 0;
  bit pending  = 0;

  initial begin
    bus.shift_idle = 1'b1;
    bus.row_ready  = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        busy = 0; pending = 0;
        bus.shift_idle = 1'b1;
        bus.row_ready  = 1'b0;
      end else begin
        if (bus.shift_start) begin
          busy = $urandom_range(max_busy, 1) + 1;
          bus.shift_idle = 1'b0;
        end else if (busy > 0) begin
          busy--;
          if (busy == 0) bus.shift_idle = 1'b1;
        end
        if (bus.row_request) begin
          if (!pending) begin
            pending = 1;
            rdelay  = $urandom_range(max_rdy, 0);
          end else if (rdelay > 0) begin
            rdelay--;
          end
          bus.row_ready = (rdelay == 0);
        end else begin
          pending = 0;
          bus.row_ready = ($urandom_range(3, 0) == 0);
        end
      end
    end
  end

  // Monitor
  int     cyc       = 0;
  bit     mon_en    = 0;
  int     lat_cyc   = 0;
  int     low_cnt   = 0;
  int     prev_win  = 0;
  bit     have_prev = 0;
  int     high_run  = 0;
  logic   prev_oe   = 1'b1;
  logic   prev_req  = 1'b0;
  logic   prev_rdy  = 1'b0;
  logic [4:0] prev_abcde = 5'd0;
  shift_t ms;
  lat_t   ml;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (mon_en) begin
        if (bus.shift_start) begin
          check("shift_expected", int'(exp_shift.size() != 0), 1);
          if (exp_shift.size() != 0) begin
            ms = exp_shift.pop_front();
            check("shift_row", int'(bus.row_index), ms.row);
            check("shift_plane", int'(bus.shift_plane), ms.plane);
            check("shift_req_low", int'(bus.row_request), 0);
            if (ms.plane == 0) check("ready_to_shift", int'(prev_req && prev_rdy), 1);
          end
        end
        if (bus.oe) high_run++;
        else begin
          high_run = 0;
          low_cnt++;
          if (prev_oe) check("oe_latency", cyc - lat_cyc, 2);
        end
        if (bus.lat) begin
          check("lat_expected", int'(exp_lat.size() != 0), 1);
          if (exp_lat.size() != 0) begin
            ml = exp_lat.pop_front();
            check("lat_abcde", int'(bus.abcde), ml.row);
            check("lat_row_index", int'(bus.row_index), ml.row);
            check("lat_plane", int'(bus.shift_plane), ml.plane);
            check("lat_frame_done", int'(bus.frame_done), ml.fd);
            check("lat_oe_high", int'(bus.oe), 1);
            if (ml.plane == 0) check("blank_before_lat", int'(high_run >= BLK + 1), 1);
            if (have_prev) check("oe_window", low_cnt, prev_win);
            have_prev = 1; prev_win = ml.win; low_cnt = 0; lat_cyc = cyc;
          end
        end
        if (bus.frame_done) check("frame_done_with_lat", int'(bus.lat), 1);
        if (bus.abcde != prev_abcde) check("abcde_in_blank", int'(bus.oe), 1);
        if (prev_req && !bus.row_request) check("req_held_until_ready", int'(prev_rdy), 1);
      end
      prev_oe    = bus.oe;
      prev_req   = bus.row_request;
      prev_rdy   = bus.row_ready;
      prev_abcde = bus.abcde;
    end
  end

  task automatic run_frames(int nf, int mb, int mr, int dimv);
    int budget;
    int dv;
    dv = 0;
`ifdef BCM_DIMMING_EN
    dv  = dimv;
    dim = 3'(dimv);
`endif
    max_busy = mb;
    max_rdy  = mr;
    push_frames(nf, dv);
    @(posedge clock); #1;
    enable = 1'b1;
    budget = 0;
    while (exp_lat.size() > RC * PC - 1 && budget < 3000) begin
      @(posedge clock); #1; budget++;
    end
    enable = 1'b0;
    while (exp_lat.size() != 0 && budget < 3000) begin
      @(posedge clock); #1; budget++;
    end
    check("run_drained", exp_lat.size(), 0);
    repeat ((BT << (PC - 1)) + 8) @(posedge clock);
    #1;
    if (have_prev) check("oe_window_last", low_cnt, prev_win);
    have_prev = 0;
    check("idle_no_request", int'(bus.row_request), 0);
    check("idle_oe", int'(bus.oe), 1);
    check("shift_queue_empty", exp_shift.size(), 0);
    exp_shift.delete();
    exp_lat.delete();
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_oe", int'(bus.oe), 1);
    check("reset_lat", int'(bus.lat), 0);
    check("reset_shift_start", int'(bus.shift_start), 0);
    check("reset_row_request", int'(bus.row_request), 0);
    check("reset_abcde", int'(bus.abcde), 0);
    check("reset_frame_done", int'(bus.frame_done), 0);
    enable = 1'b0;
    reset  = 1'b0;
    mon_en = 1;

    run_frames(2, 3, 0, 0);
    run_frames(1, 20, 10, 1);
    for (int i = 0; i < 6; i++)
      run_frames($urandom_range(2, 1), $urandom_range(25, 1),
                 $urandom_range(10, 0), $urandom_range(3, 0));

    // reset in the middle of a lit row-1 window
    mon_en   = 0;
    max_busy = 3;
    max_rdy  = 0;
`ifdef BCM_DIMMING_EN
    dim = 3'd0;
`endif
    enable = 1'b1;
    n = 0;
    while (!(bus.oe == 1'b0 && bus.abcde == 5'd1) && n < 500) begin
      @(posedge clock); #1; n++;
    end
    check("reached_row1_window", int'(bus.oe == 1'b0 && bus.abcde == 5'd1), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midreset_oe", int'(bus.oe), 1);
    check("midreset_lat", int'(bus.lat), 0);
    check("midreset_shift_start", int'(bus.shift_start), 0);
    check("midreset_row_request", int'(bus.row_request), 0);
    check("midreset_abcde", int'(bus.abcde), 0);
    check("midreset_frame_done", int'(bus.frame_done), 0);
    enable = 1'b0;
    reset  = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("after_reset_oe_stays_high", int'(bus.oe), 1);
    have_prev = 0;
    mon_en    = 1;
    run_frames(1, 3, 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
